// File: rtl/md_pkg.sv
// Shared constants and types for the E-stage multiply/divide unit.
// The hazard unit imports these as well.
package md_pkg;

   localparam logic [5:0] OP_SPECIAL = 6'b000000;

   localparam logic [5:0] FUNC_MFHI  = 6'b010000;
   localparam logic [5:0] FUNC_MTHI  = 6'b010001;
   localparam logic [5:0] FUNC_MFLO  = 6'b010010;
   localparam logic [5:0] FUNC_MTLO  = 6'b010011;
   localparam logic [5:0] FUNC_MULT  = 6'b011000;
   localparam logic [5:0] FUNC_MULTU = 6'b011001;
   localparam logic [5:0] FUNC_DIV   = 6'b011010;
   localparam logic [5:0] FUNC_DIVU  = 6'b011011;

   typedef enum logic {
      MD_IDLE = 1'b0,
      MD_BUSY = 1'b1
   } md_state_t;

   typedef enum logic [1:0] {
      NONE = 2'd0,
      MULT = 2'd1,
      DIV  = 2'd2,
      MOVE = 2'd3
   } md_kind_t;

endpackage

// File: rtl/md_decode.sv
// Classifies the E-stage instruction into a mult/div/move kind, plus the
// signed flag (mult/div) and the HI-select flag (mthi vs mtlo).
module md_decode
   import md_pkg::*;
(
   input  logic       en,
   input  logic [5:0] op,
   input  logic [5:0] func,
   output md_kind_t   kind,
   output logic       is_signed,
   output logic       hi_sel
);

   always_comb begin
      kind      = NONE;
      is_signed = 1'b0;
      hi_sel    = 1'b0;
      if (en && (op == OP_SPECIAL)) begin
         case (func)
            FUNC_MULT:  begin kind = MULT; is_signed = 1'b1; end
            FUNC_MULTU: kind = MULT;
            FUNC_DIV:   begin kind = DIV;  is_signed = 1'b1; end
            FUNC_DIVU:  kind = DIV;
            FUNC_MTHI:  begin kind = MOVE; hi_sel = 1'b1; end
            FUNC_MTLO:  kind = MOVE;
            default:    kind = NONE;
         endcase
      end
   end

endmodule

// File: rtl/md_sequencer.sv
// Fixed-latency multiply/divide sequencer owning HI/LO. The result is computed
// at accept and held in pending registers until the busy window ends.
//
// state   | meaning
// --------+--------------------------------------------------------------
// MD_IDLE | accepts mult/div (start) or performs mthi/mtlo immediately
// MD_BUSY | counting down; pending result committed when counter hits 1
module md_sequencer
   import md_pkg::*;
#(
   parameter int MUL_CYCLES = 5,
   parameter int DIV_CYCLES = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic [5:0]  op,
   input  logic [5:0]  func,
   input  logic [31:0] rs_data,
   input  logic [31:0] rt_data,
   output logic        start,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam logic [3:0] MUL_CNT = 4'(MUL_CYCLES);
   localparam logic [3:0] DIV_CNT = 4'(DIV_CYCLES);

   md_state_t   state, state_nxt;
   logic [3:0]  cnt, cnt_nxt;
   logic        busy_nxt;
   logic [31:0] hi_nxt, lo_nxt;
   logic [31:0] pend_hi, pend_lo, pend_hi_nxt, pend_lo_nxt;
   logic        pend_wr, pend_wr_nxt;

   md_kind_t    kind;
   logic        is_signed;
   logic        hi_sel;

   md_decode u_decode (
      .en        (en),
      .op        (op),
      .func      (func),
      .kind      (kind),
      .is_signed (is_signed),
      .hi_sel    (hi_sel)
   );

   logic [63:0] prod_s, prod_u;
   assign prod_s = $signed({{32{rs_data[31]}}, rs_data}) * $signed({{32{rt_data[31]}}, rt_data});
   assign prod_u = {32'd0, rs_data} * {32'd0, rt_data};

   // Signed division goes through magnitudes so 0x80000000 / -1 wraps cleanly
   // instead of relying on simulator/host overflow behaviour.
   logic        a_neg, b_neg;
   logic [31:0] a_mag, b_mag, q_mag, r_mag;
   logic [31:0] quot_s, rem_s, quot_u, rem_u;

   always_comb begin
      a_neg  = is_signed & rs_data[31];
      b_neg  = is_signed & rt_data[31];
      a_mag  = a_neg ? (32'd0 - rs_data) : rs_data;
      b_mag  = b_neg ? (32'd0 - rt_data) : rt_data;
      if (b_mag == 32'd0) begin
         b_mag = 32'd1;
      end
      q_mag  = a_mag / b_mag;
      r_mag  = a_mag % b_mag;
      quot_s = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
      rem_s  = a_neg ? (32'd0 - r_mag) : r_mag;
      quot_u = q_mag;
      rem_u  = r_mag;
   end

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      busy_nxt    = busy;
      hi_nxt      = hi;
      lo_nxt      = lo;
      pend_hi_nxt = pend_hi;
      pend_lo_nxt = pend_lo;
      pend_wr_nxt = pend_wr;
      start       = 1'b0;
      case (state)
         MD_IDLE: begin
            case (kind)
               MULT: begin
                  start       = 1'b1;
                  pend_hi_nxt = is_signed ? prod_s[63:32] : prod_u[63:32];
                  pend_lo_nxt = is_signed ? prod_s[31:0]  : prod_u[31:0];
                  pend_wr_nxt = 1'b1;
                  cnt_nxt     = MUL_CNT;
                  busy_nxt    = 1'b1;
                  state_nxt   = MD_BUSY;
               end
               DIV: begin
                  start       = 1'b1;
                  pend_hi_nxt = is_signed ? rem_s  : rem_u;
                  pend_lo_nxt = is_signed ? quot_s : quot_u;
                  pend_wr_nxt = (rt_data != 32'd0);
                  cnt_nxt     = DIV_CNT;
                  busy_nxt    = 1'b1;
                  state_nxt   = MD_BUSY;
               end
               MOVE: begin
                  if (hi_sel) begin
                     hi_nxt = rs_data;
                  end else begin
                     lo_nxt = rs_data;
                  end
               end
               default: ;
            endcase
         end
         MD_BUSY: begin
            if (cnt == 4'd1) begin
               if (pend_wr) begin
                  hi_nxt = pend_hi;
                  lo_nxt = pend_lo;
               end
               cnt_nxt   = 4'd0;
               busy_nxt  = 1'b0;
               state_nxt = MD_IDLE;
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         default: state_nxt = MD_IDLE;
      endcase
      if (reset) begin
         start = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= MD_IDLE;
         cnt     <= 4'd0;
         busy    <= 1'b0;
         hi      <= 32'd0;
         lo      <= 32'd0;
         pend_hi <= 32'd0;
         pend_lo <= 32'd0;
         pend_wr <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         busy    <= busy_nxt;
         hi      <= hi_nxt;
         lo      <= lo_nxt;
         pend_hi <= pend_hi_nxt;
         pend_lo <= pend_lo_nxt;
         pend_wr <= pend_wr_nxt;
      end
   end

endmodule

// File: tb/tb_md_sequencer.sv
// Directed-vector bench for md_sequencer with hand-computed HI/LO results
// and busy-window lengths.
module tb_md_sequencer;
   import md_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        en;
   logic [5:0]  op;
   logic [5:0]  func;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic        start;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;

   int n_vec  = 0;
   int n_miss = 0;

   always #5 clk = ~clk;

   md_sequencer #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk     (clk),
      .reset   (reset),
      .en      (en),
      .op      (op),
      .func    (func),
      .rs_data (rs_data),
      .rt_data (rt_data),
      .start   (start),
      .busy    (busy),
      .hi      (hi),
      .lo      (lo)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic present(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
      en      = 1'b1;
      op      = OP_SPECIAL;
      func    = f;
      rs_data = a;
      rt_data = b;
   endtask

   // Scrambles operands so a design that samples them late gets caught.
   task automatic idle_in();
      en      = 1'b0;
      op      = OP_SPECIAL;
      func    = FUNC_MULT;
      rs_data = $urandom;
      rt_data = $urandom;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(inout int cyc);
      while (busy === 1'b1 && cyc < 40) begin
         cyc++;
         tick();
      end
   endtask

   task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                         input logic [31:0] b, input int n, input logic [31:0] eh,
                         input logic [31:0] el);
      int cyc;
      present(f, a, b);
      #1;
      chk({tag, " start"}, 64'(start), 64'd1);
      tick();
      idle_in();
      #1;
      chk({tag, " start_drop"}, 64'(start), 64'd0);
      cyc = 0;
      wait_done(cyc);
      chk({tag, " busy_cycles"}, 64'(cyc), 64'(n));
      chk({tag, " hi"}, 64'(hi), 64'(eh));
      chk({tag, " lo"}, 64'(lo), 64'(el));
   endtask

   task automatic move(input string tag, input logic [5:0] f, input logic [31:0] a,
                       input logic [31:0] eh, input logic [31:0] el);
      present(f, a, 32'h0);
      #1;
      chk({tag, " start"}, 64'(start), 64'd0);
      tick();
      idle_in();
      chk({tag, " busy"}, 64'(busy), 64'd0);
      chk({tag, " hi"}, 64'(hi), 64'(eh));
      chk({tag, " lo"}, 64'(lo), 64'(el));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int cyc;
      reset = 1'b1;
      present(FUNC_MULT, 32'd3, 32'd4);
      #1;
      chk("reset start", 64'(start), 64'd0);
      tick();
      tick();
      chk("reset busy", 64'(busy), 64'd0);
      chk("reset hi", 64'(hi), 64'd0);
      chk("reset lo", 64'(lo), 64'd0);
      idle_in();
      #2 reset = 1'b0;

      run_op("mult", FUNC_MULT, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
      run_op("multu", FUNC_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'h0000_0001);
      run_op("div neg dividend", FUNC_DIV, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_op("div neg divisor", FUNC_DIV, 32'd7, 32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD);

      move("mthi", FUNC_MTHI, 32'h12, 32'h12, 32'hFFFF_FFFD);
      move("mtlo", FUNC_MTLO, 32'h34, 32'h12, 32'h34);
      run_op("divu by zero", FUNC_DIVU, 32'd7, 32'd0, 10, 32'h12, 32'h34);
      move("mthi deadbeef", FUNC_MTHI, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h34);
      run_op("div overflow", FUNC_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0, 32'h8000_0000);

      present(FUNC_MULT, 32'd2, 32'd2);
      en = 1'b0;
      #1;
      chk("en low start", 64'(start), 64'd0);
      tick();
      chk("en low busy", 64'(busy), 64'd0);

      present(FUNC_MULT, 32'd2, 32'd2);
      op = 6'b000001;
      #1;
      chk("non-special start", 64'(start), 64'd0);
      tick();
      chk("non-special busy", 64'(busy), 64'd0);
      idle_in();

      // div 100/7 with a mult and an mthi presented while busy; neither may land
      present(FUNC_DIV, 32'd100, 32'd7);
      #1;
      chk("busy div start", 64'(start), 64'd1);
      tick();
      idle_in();
      tick();
      present(FUNC_MULT, 32'd3, 32'd3);
      #1;
      chk("busy mult start", 64'(start), 64'd0);
      tick();
      present(FUNC_MTHI, 32'h55, 32'd0);
      #1;
      chk("busy mthi start", 64'(start), 64'd0);
      tick();
      idle_in();
      cyc = 3;
      wait_done(cyc);
      chk("busy div busy_cycles", 64'(cyc), 64'd10);
      chk("busy div hi", 64'(hi), 64'd2);
      chk("busy div lo", 64'(lo), 64'd14);

      // async reset in busy cycle 3 of a div
      present(FUNC_DIV, 32'd100, 32'd3);
      #1;
      tick();
      idle_in();
      tick();
      tick();
      #2 reset = 1'b1;
      #1;
      chk("midop reset busy", 64'(busy), 64'd0);
      chk("midop reset hi", 64'(hi), 64'd0);
      chk("midop reset lo", 64'(lo), 64'd0);
      #2 reset = 1'b0;
      run_op("mult after reset", FUNC_MULT, 32'd4, 32'd5, 5, 32'd0, 32'd20);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
